// File: rtl/core_boot_controller.sv
// Boot/run controller for a RISC-V core: streams a program image into instruction memory,
// releases the core with a start pulse, then times the run until the done PC or a timeout.
module core_boot_controller #(
  parameter int          ADDRESS_BITS   = 20,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [31:0] DONE_PC        = 32'h000000b0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [DATA_WIDTH-1:0]   i_load_data,
  input  logic                    i_load_last,
  input  logic [ADDRESS_BITS-1:0] i_boot_address,
  output logic                    o_mem_write,
  output logic [ADDRESS_BITS-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0]   o_mem_data,
  output logic                    o_core_reset,
  output logic                    o_core_start,
  output logic [ADDRESS_BITS-1:0] o_core_prog_address,
  input  logic [31:0]             i_core_pc,
  output logic                    o_done,
  output logic                    o_timeout,
  output logic [31:0]             o_cycle_count
);

  typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_DONE} state_t;

  localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

  state_t                  r_state, w_next;
  logic [ADDRESS_BITS-1:0] r_word_cnt;
  logic [ADDRESS_BITS-1:0] r_prog_address;
  logic [31:0]             r_cycle_count;
  logic                    r_done, r_timeout;
  logic                    w_accept, w_pc_hit, w_to_hit;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_pc_hit = 1'b0;
    w_to_hit = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_accept = i_load_valid & ~reset;
        if (w_accept && i_load_last) w_next = S_START;
      end
      S_START: w_next = S_RUN;
      S_RUN: begin
        w_pc_hit = (i_core_pc == DONE_PC);
        w_to_hit = (TIMEOUT_VAL != 32'd0) && (r_cycle_count == TIMEOUT_VAL);
        if (w_pc_hit || w_to_hit) w_next = S_DONE;
      end
      default: w_next = S_DONE;
    endcase
  end

  // The count is frozen at the value it shows in the terminating RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_cnt     <= '0;
      r_prog_address <= '0;
      r_cycle_count  <= '0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      if (w_accept) r_word_cnt <= r_word_cnt + ADDRESS_BITS'(1);
      if (w_accept && i_load_last) r_prog_address <= i_boot_address;
      if (r_state == S_START) r_cycle_count <= r_cycle_count + 32'd1;
      if (r_state == S_RUN) begin
        if (w_pc_hit || w_to_hit) begin
          r_done    <= 1'b1;
          r_timeout <= w_to_hit & ~w_pc_hit;
        end else if (r_cycle_count != 32'hFFFF_FFFF) begin
          r_cycle_count <= r_cycle_count + 32'd1;
        end
      end
    end
  end

  assign o_load_ready        = (r_state == S_LOAD) & ~reset;
  assign o_mem_write         = w_accept;
  assign o_mem_address       = r_word_cnt;
  assign o_mem_data          = i_load_data;
  assign o_core_reset        = reset | ~((r_state == S_START) | (r_state == S_RUN));
  assign o_core_start        = (r_state == S_START) & ~reset;
  assign o_core_prog_address = r_prog_address;
  assign o_done              = r_done;
  assign o_timeout           = r_timeout;
  assign o_cycle_count       = r_cycle_count;

endmodule

// File: tb/tb_core_boot_controller.sv
// Directed bench: two controllers (timeout off / timeout 50) share the load stream;
// memory writes are checked against a queue filled as beats are driven.
module tb_core_boot_controller;
  localparam int AB = 20;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0, load_last = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [AB-1:0] boot_address = '0;
  logic [31:0]   pc0 = '0, pc1 = '0;

  logic          load_ready, mem_write, core_reset, core_start, done, timeout;
  logic [AB-1:0] mem_address, prog_address;
  logic [DW-1:0] mem_data;
  logic [31:0]   cycle_count;

  logic          t_load_ready, t_mem_write, t_core_reset, t_core_start, t_done, t_timeout;
  logic [AB-1:0] t_mem_address, t_prog_address;
  logic [DW-1:0] t_mem_data;
  logic [31:0]   t_cycle_count;

  int n_asrt = 0;
  int n_fail = 0;

  typedef struct { logic [AB-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t           exp_q[$];
  logic [AB-1:0] exp_addr = '0;

  always #5 clock = ~clock;

  core_boot_controller #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .DONE_PC(32'hb0), .TIMEOUT_CYCLES(0)) u_dut (
    .clock(clock), .reset(reset), .i_load_valid(load_valid), .o_load_ready(load_ready),
    .i_load_data(load_data), .i_load_last(load_last), .i_boot_address(boot_address),
    .o_mem_write(mem_write), .o_mem_address(mem_address), .o_mem_data(mem_data),
    .o_core_reset(core_reset), .o_core_start(core_start), .o_core_prog_address(prog_address),
    .i_core_pc(pc0), .o_done(done), .o_timeout(timeout), .o_cycle_count(cycle_count));

  core_boot_controller #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .DONE_PC(32'hb0), .TIMEOUT_CYCLES(50)) u_dut_to (
    .clock(clock), .reset(reset), .i_load_valid(load_valid), .o_load_ready(t_load_ready),
    .i_load_data(load_data), .i_load_last(load_last), .i_boot_address(boot_address),
    .o_mem_write(t_mem_write), .o_mem_address(t_mem_address), .o_mem_data(t_mem_data),
    .o_core_reset(t_core_reset), .o_core_start(t_core_start), .o_core_prog_address(t_prog_address),
    .i_core_pc(pc1), .o_done(t_done), .o_timeout(t_timeout), .o_cycle_count(t_cycle_count));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest expected beat.
  always @(negedge clock) begin
    if (mem_write === 1'b1) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_address), 64'(e.addr));
        chk("wr_data", 64'(mem_data), 64'(e.data));
      end
    end
    if (mem_write === 1'b1 || t_mem_write === 1'b1)
      chk("to_inst_write", {31'd0, t_mem_write, t_mem_address, 12'd0}, {31'd0, mem_write, mem_address, 12'd0});
  end

  task automatic beat(input logic [DW-1:0] d, input logic last, input logic [AB-1:0] boot);
    load_valid = 1'b1; load_data = d; load_last = last; boot_address = boot;
    exp_q.push_back('{exp_addr, d});
    exp_addr = exp_addr + 1'b1;
    @(posedge clock); #1;
    load_valid = 1'b0; load_last = 1'b0; load_data = 32'hdead_beef;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_core_start"}, 64'(core_start), 64'd0);
    chk({tag, "_prog_addr"}, 64'(prog_address), 64'd0);
    chk({tag, "_done"}, 64'({done, timeout, t_done, t_timeout}), 64'd0);
    chk({tag, "_count"}, 64'({cycle_count, t_cycle_count}), 64'd0);
    chk({tag, "_to_core_reset"}, 64'({t_core_reset, t_core_start}), 64'b10);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; load_valid = 1'b1; load_last = 1'b1; pc0 = '0; pc1 = '0;
    @(negedge clock);
    chk({tag, "_rst_ready"}, 64'({load_ready, t_load_ready}), 64'd0);
    chk({tag, "_rst_memwr"}, 64'({mem_write, t_mem_write}), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0; exp_addr = '0;
    @(negedge clock);
    check_reset_vals(tag);
    chk({tag, "_ready"}, 64'(load_ready), 64'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clock);
    #1;
    do_reset("init");

    // Basic 4-word load, boot address 0
    for (int i = 0; i < 4; i++) beat(32'hA000_0000 + 32'(i), i == 3, '0);
    @(negedge clock);
    chk("start_core_reset", 64'(core_reset), 64'd0);
    chk("start_pulse", 64'(core_start), 64'd1);
    chk("start_prog_addr", 64'(prog_address), 64'd0);
    chk("start_ready", 64'(load_ready), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("run1_count", 64'(cycle_count), 64'd1);
    chk("run1_start", 64'({core_start, core_reset}), 64'd0);

    // PC match on the 10th RUN cycle
    repeat (9) @(posedge clock);
    #1; pc0 = 32'hb0;
    @(negedge clock);
    chk("run10_count", 64'(cycle_count), 64'd10);
    chk("run10_done", 64'(done), 64'd0);
    @(posedge clock); #1; pc0 = '0;
    @(negedge clock);
    chk("pc_done", 64'({done, timeout}), 64'b10);
    chk("pc_count", 64'(cycle_count), 64'd10);
    chk("pc_core_reset", 64'(core_reset), 64'd1);

    // Hold in DONE while the loader pushes a stray last beat (other instance still RUN)
    load_valid = 1'b1; load_last = 1'b1; load_data = 32'h5555_aaaa;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("hold_done", 64'({done, timeout, core_reset, load_ready}), 64'b1010);
      chk("hold_count", 64'(cycle_count), 64'd10);
      chk("hold_to_run", 64'({t_done, t_core_reset, t_load_ready}), 64'd0);
    end
    load_valid = 1'b0; load_last = 1'b0;

    // Timeout instance reaches 50 without PC match
    for (k = 0; k < 200 && t_done !== 1'b1; k++) @(posedge clock);
    chk("timeout_wait", 64'(k < 200), 64'd1);
    @(negedge clock);
    chk("to_flags", 64'({t_done, t_timeout, t_core_reset}), 64'b111);
    chk("to_count", 64'(t_cycle_count), 64'd50);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("to_hold_count", 64'(t_cycle_count), 64'd50);

    // Stalled load: only valid cycles write
    @(posedge clock); #1;
    do_reset("stall");
    beat(32'hB000_0000, 1'b0, 20'h00040);
    load_last = 1'b1; @(posedge clock); #1; load_last = 1'b0;
    beat(32'hB000_0001, 1'b0, 20'h00040);
    @(posedge clock); #1;
    beat(32'hB000_0002, 1'b1, 20'h00040);
    @(negedge clock);
    chk("stall_start", 64'({core_start, t_core_start}), 64'b11);
    chk("stall_prog_addr", 64'(prog_address), 64'h40);
    chk("stall_to_prog_addr", 64'(t_prog_address), 64'h40);

    // PC match coinciding with the timeout count
    @(posedge clock); #1;
    for (k = 0; k < 200; k++) begin
      if (t_cycle_count == 32'd50) break;
      @(posedge clock); #1;
    end
    chk("tie_wait", 64'(k < 200), 64'd1);
    pc1 = 32'hb0;
    @(posedge clock); #1; pc1 = '0;
    @(negedge clock);
    chk("tie_flags", 64'({t_done, t_timeout}), 64'b10);
    chk("tie_count", 64'(t_cycle_count), 64'd50);

    // Reset mid-RUN
    chk("midrun_running", 64'({done, core_reset}), 64'd0);
    @(posedge clock); #1;
    do_reset("midrun");

    // Reset mid-LOAD, then a fresh load restarts at 0
    beat(32'hC000_0000, 1'b0, 20'h5);
    beat(32'hC000_0001, 1'b0, 20'h5);
    do_reset("midload");
    for (int i = 0; i < 3; i++) beat(32'hD000_0000 + 32'(i), i == 2, 20'h7);
    @(negedge clock);
    chk("reload_start", 64'(core_start), 64'd1);
    chk("reload_prog_addr", 64'(prog_address), 64'h7);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
